// File: rtl/prom_pkg.sv
// Shared widths and scanner state encoding for the PROM scanner slice.
package prom_pkg;
   localparam int PROM_ADDR_W = 5;
   localparam int PROM_DATA_W = 8;
   localparam int SCAN_LEN_W  = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } scan_state_e;
endpackage

// File: rtl/prom_scan_fifo.sv
// Synchronous FIFO with occupancy output and synchronous reset flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module prom_scan_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 9,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int OCC_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [OCC_W-1:0] occupancy,
   output logic             empty
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [OCC_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
   assign w_do_pop  = pop && (r_count != '0);
   assign w_do_push = push && ((r_count != OCC_W'(DEPTH)) || w_do_pop);

   // Storage array; contents need no reset because empty masks the head.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= push_data;
   end

   // Pointers and occupancy; reset flushes the queue.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign pop_data  = r_mem[r_rd_ptr];
   assign occupancy = r_count;
   assign empty     = (r_count == '0);
endmodule

// File: rtl/prom_scanner.sv
// Address sequencer + stream adapter in front of a 32x8 registered PROM.
// Optional checksum accumulator enabled by defining PROM_SCANNER_CSUM_EN.
module prom_scanner
   import prom_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [PROM_ADDR_W-1:0] base,
   input  logic [SCAN_LEN_W-1:0]  len,
   output logic [PROM_ADDR_W-1:0] prom_addr,
   input  logic [PROM_DATA_W-1:0] prom_data,
   output logic [PROM_DATA_W-1:0] out_data,
   output logic                   out_valid,
   output logic                   out_last,
   input  logic                   out_ready,
   output logic                   busy,
   output logic                   done,
   output logic [7:0]             out_csum
);
   localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

   scan_state_e            r_state;
   scan_state_e            w_next;
   logic [2:1]             r_vld_pipe;   // [1]: address at PROM, [2]: data on prom_data
   logic [PROM_ADDR_W-1:0] r_addr;
   logic [SCAN_LEN_W-1:0]  r_len;
   logic [SCAN_LEN_W-1:0]  r_issued;
   logic [SCAN_LEN_W-1:0]  r_push_cnt;
   logic                   r_done;
   logic                   w_issue;
   logic                   w_done_set;
   logic                   w_accept;
   logic                   w_hs;
   logic                   w_push;
   logic                   w_push_last;
   logic                   w_room;
   logic [OCC_W:0]         w_pending;
   logic [OCC_W-1:0]       w_occ;
   logic                   w_empty;
   logic [PROM_DATA_W:0]   w_head;

   // Reads in flight are reserved FIFO slots, so a captured byte always has room.
   assign w_pending = {1'b0, w_occ} + (OCC_W+1)'(r_vld_pipe[1]) + (OCC_W+1)'(r_vld_pipe[2]);
   assign w_room    = w_pending < (OCC_W+1)'(FIFO_DEPTH);
   assign w_accept  = (r_state == IDLE) && start;
   assign w_hs      = out_valid && out_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next-state, issue strobe and completion strobe.
   always_comb begin
      w_next     = r_state;
      w_issue    = 1'b0;
      w_done_set = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               if (len != '0) begin
                  w_issue = 1'b1;
                  w_next  = RUN;
               end else begin
                  w_done_set = 1'b1;
               end
            end
         end
         RUN: begin
            if (r_issued == r_len)  w_next  = DRAIN;
            else if (w_room)        w_issue = 1'b1;
         end
         DRAIN: begin
            if (w_hs && w_head[PROM_DATA_W]) begin
               w_done_set = 1'b1;
               w_next     = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_push      = r_vld_pipe[2];
   assign w_push_last = (r_push_cnt == r_len - 1'b1);

   // Address walk, issue/capture bookkeeping and the done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr     <= '0;
         r_len      <= '0;
         r_issued   <= '0;
         r_push_cnt <= '0;
         r_vld_pipe <= '0;
         r_done     <= 1'b0;
      end else begin
         r_vld_pipe <= {r_vld_pipe[1], w_issue};
         r_done     <= w_done_set;
         if (w_push) r_push_cnt <= r_push_cnt + 1'b1;
         if (w_accept) begin
            r_len      <= len;
            r_push_cnt <= '0;
            r_issued   <= SCAN_LEN_W'(w_issue);
            if (w_issue) r_addr <= base;
         end else if (w_issue) begin
            r_addr   <= r_addr + 1'b1;   // wraps 31 -> 0
            r_issued <= r_issued + 1'b1;
         end
      end
   end

   prom_scan_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PROM_DATA_W + 1)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push),
      .push_data ({w_push_last, prom_data}),
      .pop       (w_hs),
      .pop_data  (w_head),
      .occupancy (w_occ),
      .empty     (w_empty)
   );

   assign out_valid = !w_empty;
   assign out_data  = out_valid ? w_head[PROM_DATA_W-1:0] : '0;
   assign out_last  = out_valid ? w_head[PROM_DATA_W] : 1'b0;
   assign prom_addr = r_addr;
   assign busy      = (r_state != IDLE);
   assign done      = r_done;

`ifdef PROM_SCANNER_CSUM_EN
   logic [7:0] r_csum;

   // Running XOR of delivered bytes; cleared by an accepted start.
   always_ff @(posedge clk) begin
      if (rst)           r_csum <= '0;
      else if (w_accept) r_csum <= '0;
      else if (w_hs)     r_csum <= r_csum ^ out_data;
   end

   assign out_csum = r_csum;
`else
   assign out_csum = 8'h00;
`endif
endmodule
